// File: rtl/layer_mem_reader.sv
// layer_mem_reader
//   Read-back master for the CONV layer result memories. Takes a command
//   (bank, base address, word count). It issues one memory read per cycle
//   while read credit allows, and it streams the returned words downstream
//   over valid/ready.
//
//   The memory has a fixed one-cycle read latency, so there is at most one
//   read in flight. A 2-entry skid FIFO plus a credit check keeps the stream
//   at full rate under i_ready=1 and makes overflow impossible under
//   backpressure.
//
// Ports
//   clk, reset        clock, asynchronous active-low reset
//   i_start/i_sel/i_base/i_len   command strobe and its arguments
//   o_busy, o_done    command in progress, one-cycle completion pulse
//   o_rd/o_addr/o_sel memory read port (crd / caddr_rd / csel)
//   i_data            memory read data, valid the cycle after o_rd
//   o_valid/o_data/o_last/i_ready   output word stream
module layer_mem_reader #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 20,
   parameter int SEL_W  = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_start,
   input  logic [SEL_W-1:0]  i_sel,
   input  logic [ADDR_W-1:0] i_base,
   input  logic [ADDR_W:0]   i_len,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_rd,
   output logic [ADDR_W-1:0] o_addr,
   output logic [SEL_W-1:0]  o_sel,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_data,
   output logic              o_last,
   input  logic              i_ready
);

   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_t                  state;
   logic [SEL_W-1:0]        sel_q;
   logic [ADDR_W:0]         len_q;
   logic [ADDR_W:0]         issue_cnt;
   logic [ADDR_W:0]         recv_cnt;
   logic [ADDR_W-1:0]       addr_q;       // next address to issue
   logic [ADDR_W-1:0]       last_addr_q;  // last issued address, shown while idle
   logic                    rd_pend;      // read issued last cycle, data on i_data now
   logic                    done_q;

   logic [1:0][DATA_W-1:0]  fifo_data;
   logic [1:0]              fifo_last;
   logic                    wr_ptr;
   logic                    rd_ptr;
   logic [1:0]              fifo_cnt;

   logic                    pop;
   logic                    push;
   logic                    push_last;
   logic                    issue;
   logic [2:0]              occ;

   // Words already owed to the FIFO after this cycle. A new read lands two
   // edges from now, so it may only go out if that leaves room for it
   // even with no further pops.
   assign pop       = o_valid & i_ready;
   assign push      = rd_pend;
   assign push_last = (recv_cnt == (len_q - CNT_ONE));
   assign occ       = {1'b0, fifo_cnt} + {2'b00, rd_pend} - {2'b00, pop};
   assign issue     = (state == READ) && (occ < 3'd2);

   assign o_rd    = issue;
   assign o_addr  = issue ? addr_q : last_addr_q;
   assign o_sel   = (state != IDLE) ? sel_q : '0;
   assign o_busy  = (state != IDLE);
   assign o_done  = done_q;
   assign o_valid = (fifo_cnt != 2'd0);
   assign o_data  = fifo_data[rd_ptr];
   assign o_last  = o_valid & fifo_last[rd_ptr];

   // Command FSM and read issue
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         sel_q       <= '0;
         len_q       <= '0;
         issue_cnt   <= '0;
         addr_q      <= '0;
         last_addr_q <= '0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (i_start) begin
                  sel_q     <= i_sel;
                  addr_q    <= i_base;
                  len_q     <= i_len;
                  issue_cnt <= '0;
                  if (i_len == '0) done_q <= 1'b1;
                  else             state  <= READ;
               end
            end
            READ: begin
               if (issue) begin
                  addr_q      <= addr_q + ADDR_ONE;  // wraps at the bank end
                  last_addr_q <= addr_q;
                  issue_cnt   <= issue_cnt + CNT_ONE;
                  if ((issue_cnt + CNT_ONE) == len_q) state <= DRAIN;
               end
            end
            DRAIN: begin
               if (pop && fifo_last[rd_ptr]) begin
                  state  <= IDLE;
                  done_q <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Return capture and skid FIFO
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_pend   <= 1'b0;
         recv_cnt  <= '0;
         fifo_data <= '0;
         fifo_last <= '0;
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
         fifo_cnt  <= 2'd0;
      end else begin
         rd_pend <= issue;
         if (state == IDLE && i_start) recv_cnt <= '0;
         else if (push)                recv_cnt <= recv_cnt + CNT_ONE;
         if (push) begin
            fifo_data[wr_ptr] <= i_data;
            fifo_last[wr_ptr] <= push_last;
            wr_ptr            <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
      end
   end

endmodule

// File: tb/tb_layer_mem_reader.sv
// Testbench for layer_mem_reader: a table of per-cycle vectors for the basic
// burst, address wrap and zero-length commands, followed by hand-written
// sequences for backpressure, start-during-busy / start-on-done, and reset
// mid-command. A behavioural memory returns mem[addr] one cycle after o_rd.
module tb_layer_mem_reader;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_start;
   logic [2:0]  i_sel;
   logic [11:0] i_base;
   logic [12:0] i_len;
   logic        o_busy, o_done, o_rd, o_valid, o_last;
   logic [11:0] o_addr;
   logic [2:0]  o_sel;
   logic [19:0] i_data;
   logic [19:0] o_data;
   logic        i_ready;

   int errors = 0;
   int checks = 0;

   logic [19:0] mem [4096];

   always #5 clk = ~clk;

   layer_mem_reader #(.ADDR_W(12), .DATA_W(20), .SEL_W(3)) dut (
      .clk(clk), .reset(reset), .i_start(i_start), .i_sel(i_sel),
      .i_base(i_base), .i_len(i_len), .o_busy(o_busy), .o_done(o_done),
      .o_rd(o_rd), .o_addr(o_addr), .o_sel(o_sel), .i_data(i_data),
      .o_valid(o_valid), .o_data(o_data), .o_last(o_last), .i_ready(i_ready)
   );

   // Memory with one-cycle read latency; junk when no read was issued
   always @(posedge clk) i_data <= o_rd ? mem[o_addr] : 20'hDEADE;

   typedef struct {
      logic        start;
      logic [2:0]  sel;
      logic [11:0] base;
      logic [12:0] len;
      logic        ready;
      logic        rd;
      logic [11:0] addr;
      logic [2:0]  osel;
      logic        valid;
      logic [19:0] data;
      logic        last;
      logic        done;
      logic        busy;
   } vec_t;

   vec_t tbl [21];

   function automatic vec_t mk(input logic st, input logic [2:0] s, input logic [11:0] b,
                               input logic [12:0] l, input logic rdy, input logic rd,
                               input logic [11:0] a, input logic [2:0] os, input logic v,
                               input logic [19:0] d, input logic lst, input logic dn,
                               input logic bz);
      vec_t r;
      r.start = st; r.sel = s; r.base = b; r.len = l; r.ready = rdy;
      r.rd = rd; r.addr = a; r.osel = os; r.valid = v; r.data = d;
      r.last = lst; r.done = dn; r.busy = bz;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive inputs just after the rising edge, return at the falling edge
   task automatic step(input logic st, input logic [2:0] s, input logic [11:0] b,
                       input logic [12:0] l, input logic rdy);
      @(posedge clk);
      #1;
      i_start = st; i_sel = s; i_base = b; i_len = l; i_ready = rdy;
      @(negedge clk);
   endtask

   task automatic idle(input logic rdy);
      step(1'b0, 3'd0, 12'h000, 13'd0, rdy);
   endtask

   initial begin
      int issued, popped, done_seen, pop_now, exp_rd;
      logic stalled;
      logic [19:0] held;
      int pat [6];

      for (int i = 0; i < 4096; i++) mem[i] = 20'h50000 + 20'(i);
      mem[12'h010] = 20'hA0001; mem[12'h011] = 20'hA0002;
      mem[12'h012] = 20'hA0003; mem[12'h013] = 20'hA0004;
      mem[12'hFFE] = 20'hB0001; mem[12'hFFF] = 20'hB0002;
      mem[12'h000] = 20'hB0003; mem[12'h001] = 20'hB0004;

      // Burst, wrap, zero-length
      tbl[0]  = mk(1,1,12'h010,13'd4,1, 0,12'h000,0,0,20'h0,0,0,0);
      tbl[1]  = mk(0,0,12'h000,13'd0,1, 1,12'h010,1,0,20'h0,0,0,1);
      tbl[2]  = mk(0,0,12'h000,13'd0,1, 1,12'h011,1,0,20'h0,0,0,1);
      tbl[3]  = mk(0,0,12'h000,13'd0,1, 1,12'h012,1,1,20'hA0001,0,0,1);
      tbl[4]  = mk(0,0,12'h000,13'd0,1, 1,12'h013,1,1,20'hA0002,0,0,1);
      tbl[5]  = mk(0,0,12'h000,13'd0,1, 0,12'h013,1,1,20'hA0003,0,0,1);
      tbl[6]  = mk(0,0,12'h000,13'd0,1, 0,12'h013,1,1,20'hA0004,1,0,1);
      tbl[7]  = mk(0,0,12'h000,13'd0,1, 0,12'h013,0,0,20'h0,0,1,0);
      tbl[8]  = mk(0,0,12'h000,13'd0,1, 0,12'h013,0,0,20'h0,0,0,0);
      tbl[9]  = mk(1,2,12'hFFE,13'd4,1, 0,12'h013,0,0,20'h0,0,0,0);
      tbl[10] = mk(0,0,12'h000,13'd0,1, 1,12'hFFE,2,0,20'h0,0,0,1);
      tbl[11] = mk(0,0,12'h000,13'd0,1, 1,12'hFFF,2,0,20'h0,0,0,1);
      tbl[12] = mk(0,0,12'h000,13'd0,1, 1,12'h000,2,1,20'hB0001,0,0,1);
      tbl[13] = mk(0,0,12'h000,13'd0,1, 1,12'h001,2,1,20'hB0002,0,0,1);
      tbl[14] = mk(0,0,12'h000,13'd0,1, 0,12'h001,2,1,20'hB0003,0,0,1);
      tbl[15] = mk(0,0,12'h000,13'd0,1, 0,12'h001,2,1,20'hB0004,1,0,1);
      tbl[16] = mk(0,0,12'h000,13'd0,1, 0,12'h001,0,0,20'h0,0,1,0);
      tbl[17] = mk(0,0,12'h000,13'd0,1, 0,12'h001,0,0,20'h0,0,0,0);
      tbl[18] = mk(1,3,12'h555,13'd0,1, 0,12'h001,0,0,20'h0,0,0,0);
      tbl[19] = mk(0,0,12'h000,13'd0,1, 0,12'h001,0,0,20'h0,0,1,0);
      tbl[20] = mk(0,0,12'h000,13'd0,1, 0,12'h001,0,0,20'h0,0,0,0);

      // Reset state
      reset = 1'b0; i_start = 0; i_sel = 0; i_base = 0; i_len = 0; i_ready = 0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(o_busy), 0);
      chk("rst_done", 32'(o_done), 0);
      chk("rst_rd", 32'(o_rd), 0);
      chk("rst_addr", 32'(o_addr), 0);
      chk("rst_sel", 32'(o_sel), 0);
      chk("rst_valid", 32'(o_valid), 0);
      chk("rst_last", 32'(o_last), 0);
      reset = 1'b1;

      for (int i = 0; i < 21; i++) begin
         step(tbl[i].start, tbl[i].sel, tbl[i].base, tbl[i].len, tbl[i].ready);
         chk($sformatf("row%0d_rd", i), 32'(o_rd), 32'(tbl[i].rd));
         chk($sformatf("row%0d_addr", i), 32'(o_addr), 32'(tbl[i].addr));
         chk($sformatf("row%0d_sel", i), 32'(o_sel), 32'(tbl[i].osel));
         chk($sformatf("row%0d_valid", i), 32'(o_valid), 32'(tbl[i].valid));
         if (tbl[i].valid) chk($sformatf("row%0d_data", i), 32'(o_data), 32'(tbl[i].data));
         chk($sformatf("row%0d_last", i), 32'(o_last), 32'(tbl[i].last));
         chk($sformatf("row%0d_done", i), 32'(o_done), 32'(tbl[i].done));
         chk($sformatf("row%0d_busy", i), 32'(o_busy), 32'(tbl[i].busy));
      end

      // Backpressure: len=8, i_ready pattern 1,0,0,1,0,1 repeating
      pat = '{1, 0, 0, 1, 0, 1};
      issued = 0; popped = 0; done_seen = 0; stalled = 1'b0; held = '0;
      step(1'b1, 3'd1, 12'h100, 13'd8, 1'b1);
      for (int k = 0; k < 200 && done_seen == 0; k++) begin
         idle(pat[k % 6] != 0);
         pop_now = (o_valid && i_ready) ? 1 : 0;
         if (stalled) begin
            chk("bp_hold_valid", 32'(o_valid), 1);
            chk("bp_hold_data", 32'(o_data), 32'(held));
         end
         exp_rd = (issued < 8 && (issued - popped - pop_now) < 2) ? 1 : 0;
         chk("bp_rd", 32'(o_rd), 32'(exp_rd));
         if (o_rd) begin
            chk("bp_addr", 32'(o_addr), 32'(12'h100 + 12'(issued)));
            issued++;
         end
         if (pop_now != 0) begin
            chk("bp_data", 32'(o_data), 32'(mem[12'h100 + 12'(popped)]));
            chk("bp_last", 32'(o_last), (popped == 7) ? 1 : 0);
            popped++;
         end
         stalled = o_valid & ~i_ready;
         held    = o_data;
         if (o_done) done_seen++;
      end
      chk("bp_issued", 32'(issued), 8);
      chk("bp_popped", 32'(popped), 8);
      chk("bp_done_seen", 32'(done_seen), 1);
      idle(1'b1);
      chk("bp_done_pulse", 32'(o_done), 0);

      // Start ignored while busy, accepted in the o_done cycle
      step(1'b1, 3'd3, 12'h200, 13'd3, 1'b1);
      idle(1'b1);
      chk("s6_rd0", 32'(o_addr), 32'h200);
      step(1'b1, 3'd4, 12'h300, 13'd2, 1'b1);
      chk("s6_rd1", 32'(o_addr), 32'h201);
      idle(1'b1);
      chk("s6_rd2_addr", 32'(o_addr), 32'h202);
      chk("s6_rd2_sel", 32'(o_sel), 3);
      chk("s6_w0", 32'(o_data), 32'(mem[12'h200]));
      idle(1'b1);
      chk("s6_w1", 32'(o_data), 32'(mem[12'h201]));
      idle(1'b1);
      chk("s6_w2", 32'(o_data), 32'(mem[12'h202]));
      chk("s6_w2_last", 32'(o_last), 1);
      step(1'b1, 3'd5, 12'h040, 13'd2, 1'b1);
      chk("s6_done", 32'(o_done), 1);
      chk("s6_done_busy", 32'(o_busy), 0);
      idle(1'b1);
      chk("s6_new_rd", 32'(o_rd), 1);
      chk("s6_new_addr", 32'(o_addr), 32'h040);
      chk("s6_new_sel", 32'(o_sel), 5);
      idle(1'b1);
      chk("s6_new_addr1", 32'(o_addr), 32'h041);
      idle(1'b1);
      chk("s6_new_w0", 32'(o_data), 32'(mem[12'h040]));
      idle(1'b1);
      chk("s6_new_w1", 32'(o_data), 32'(mem[12'h041]));
      chk("s6_new_last", 32'(o_last), 1);
      idle(1'b1);
      chk("s6_new_done", 32'(o_done), 1);

      // Reset mid-READ abandons the command
      step(1'b1, 3'd6, 12'h000, 13'd100, 1'b1);
      repeat (4) idle(1'b1);
      chk("r1_busy_pre", 32'(o_busy), 1);
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("r1_rd", 32'(o_rd), 0);
      chk("r1_busy", 32'(o_busy), 0);
      chk("r1_valid", 32'(o_valid), 0);
      chk("r1_sel", 32'(o_sel), 0);
      chk("r1_addr", 32'(o_addr), 0);
      chk("r1_done", 32'(o_done), 0);
      @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         idle(1'b1);
         chk("r1_no_done", 32'(o_done), 0);
         chk("r1_no_valid", 32'(o_valid), 0);
      end
      step(1'b1, 3'd1, 12'h010, 13'd2, 1'b1);
      idle(1'b1);
      chk("r1_new_addr", 32'(o_addr), 32'h010);
      idle(1'b1);
      idle(1'b1);
      chk("r1_new_w0", 32'(o_data), 32'hA0001);
      idle(1'b1);
      chk("r1_new_w1", 32'(o_data), 32'hA0002);
      chk("r1_new_last", 32'(o_last), 1);
      idle(1'b1);
      chk("r1_new_done", 32'(o_done), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
